// File: rtl/logic_op_checker.sv
// logic_op_checker: hardware self-test engine for a two-operand AND/OR/XOR
// logic unit. On an accepted start it sweeps every {a,b} operand pair, holds
// each pair for SETTLE cycles, then compares the unit's three results with
// locally computed values. It counts mismatching vectors (saturating) and
// captures the first failing vector. Outcome is reported through
// start/busy/done plus pass.
//
// Optional build macro: LOGIC_OP_CHECKER_STOP_ON_FAIL_EN
//   defined   - the first mismatching vector ends the sweep immediately
//   undefined - the whole sweep always runs and every mismatch is counted
//
// Parameters:
//   WIDTH  operand width; the sweep covers 2^(2*WIDTH) vectors
//   SETTLE cycles between driving a vector and sampling results (1..15)
//   ERR_W  mismatch counter width
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      sweep request, sampled only while idle
//   busy       sweep in progress (waiting or checking)
//   done       one-cycle pulse at the end of a sweep
//   pass       last sweep had no mismatches; held until the next start
//   err_count  number of mismatching vectors, saturating at all-ones
//   fail_valid fail_vec holds a captured vector
//   fail_vec   {a,b} of the first failing vector
//   a_o, b_o   operands driven into the logic unit
//   and_i, or_i, xor_i  results returned by the logic unit
module logic_op_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [ERR_W-1:0]   err_count,
  output logic               fail_valid,
  output logic [2*WIDTH-1:0] fail_vec,
  output logic [WIDTH-1:0]   a_o,
  output logic [WIDTH-1:0]   b_o,
  input  logic [WIDTH-1:0]   and_i,
  input  logic [WIDTH-1:0]   or_i,
  input  logic [WIDTH-1:0]   xor_i
);

  localparam int VW = 2 * WIDTH;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [VW-1:0]    vec_q;
  logic [3:0]       settle_q;
  logic [ERR_W-1:0] err_q;
  logic             fail_valid_q;
  logic [VW-1:0]    fail_vec_q;
  logic             pass_q;
  logic             busy_q;
  logic             done_q;

  logic             mismatch;
  logic             last_vec;
  logic             finish;
  logic [ERR_W-1:0] err_d;

  assign a_o = vec_q[VW-1:WIDTH];
  assign b_o = vec_q[WIDTH-1:0];

  // Compare against the expected results of the vector currently driven.
  assign mismatch = (and_i != (a_o & b_o)) ||
                    (or_i  != (a_o | b_o)) ||
                    (xor_i != (a_o ^ b_o));
  assign last_vec = &vec_q;

  // Count after this CHECK; holds once all-ones is reached.
  always_comb begin
    err_d = err_q;
    if (mismatch && !(&err_q)) begin
      err_d = err_q + 1'b1;
    end
  end

`ifdef LOGIC_OP_CHECKER_STOP_ON_FAIL_EN
  assign finish = last_vec || mismatch;
`else
  assign finish = last_vec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            vec_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            pass_q       <= 1'b0;
            settle_q     <= SETTLE_LD;
            busy_q       <= 1'b1;
            state_q      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (settle_q == 4'd0) begin
            state_q <= ST_CHECK;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        ST_CHECK: begin
          err_q <= err_d;
          if (mismatch && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_vec_q   <= vec_q;
          end
          if (finish) begin
            // done/pass are registered on entry so they line up with DONE.
            pass_q  <= (err_d == '0);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            vec_q    <= vec_q + 1'b1;
            settle_q <= SETTLE_LD;
            state_q  <= ST_WAIT;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;

endmodule
